fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side types and constants for the RV32 front end.
package fetch_stage_pkg;

  localparam logic [31:0] BOOT_OFFSET = 32'h0000_8000;
  localparam logic [31:0] BOOT_ADDR   = BOOT_OFFSET;
  localparam logic [31:0] INSTR_LEN   = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state;

  // One buffered instruction: fetch address plus returned word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the memory bus and decode.
// Flush wins over push/pop; push is accepted when full only alongside a pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointer/count bookkeeping and entry storage; entries clear on reset so
  // the head outputs read zero until the first word lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns the fetch PC, runs one-outstanding req/gnt/rvalid
// transactions and buffers returned words for decode. Redirects flush the
// buffer and mark any in-flight response as stale.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = fetch_stage_pkg::BOOT_ADDR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state   state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q;
  logic         discard_q;
  logic         rv_accept, push, pop;
  logic [CW-1:0] count;
  logic         fifo_full, fifo_empty;
  logic [OW-1:0] occ_after;
  fetch_entry_t head, wentry;

  // Responses only count while we are waiting for one; anything else is noise
  assign rv_accept = (state_q == FETCH_WAIT) && instr_rvalid_i;
  assign push      = rv_accept && !discard_q && !redirect_i;
  assign pop       = !fifo_empty && instr_ready_i;
  assign occ_after = OW'(count) + OW'(push) - OW'(pop);
  // addr_q is frozen through REQ and WAIT, so it is the PC of the returning word
  assign wentry    = '{pc: addr_q, instr: instr_rdata_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (redirect_i),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FETCH_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: at most one request in flight, and a new one only when
  // its word is guaranteed a slot
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: if (!fifo_full) state_d = FETCH_REQ;
      FETCH_REQ:  if (instr_gnt_i) state_d = FETCH_WAIT;
      FETCH_WAIT: if (instr_rvalid_i)
                    state_d = (redirect_i || occ_after < OW'(FIFO_DEPTH)) ? FETCH_REQ
                                                                          : FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    instr_req_o = (state_q == FETCH_REQ);
  end

  // Next fetch PC: a stale (discarded) grant must not advance the new stream
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i)
      fetch_pc_d = redirect_pc_i & ~32'h3;
    else if (state_q == FETCH_REQ && instr_gnt_i && !discard_q)
      fetch_pc_d = fetch_pc_q + INSTR_LEN;
  end

  // Fetch PC and request address; the address is captured on entry to REQ
  // and held until the response returns
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= BOOT_ADDR;
      addr_q     <= BOOT_ADDR;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (state_d == FETCH_REQ && state_q != FETCH_REQ) addr_q <= fetch_pc_d;
    end
  end

  // Discard flag: a redirect while a request is pending (granted or not)
  // poisons that request's response; an rvalid in the redirect cycle is
  // dropped directly and leaves nothing pending
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           discard_q <= 1'b0;
    else if (redirect_i) discard_q <= (state_q == FETCH_REQ) ||
                                      (state_q == FETCH_WAIT && !instr_rvalid_i);
    else if (rv_accept)  discard_q <= 1'b0;
  end

  assign instr_addr_o  = addr_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_rdata_o = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized phase, all
// checked against an in-order PC stream model and a simple memory responder.
module tb_fetch_stage;

  localparam logic [31:0] BOOT = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  fetch_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .instr_valid_o  (instr_valid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory responder state
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  int          pend_dly = 0;
  // knobs
  int gnt_pct = 100, rdy_pct = 100, dly_max = 0, redir_pct = 0;
  bit force_redir = 0, force_rv = 0;
  logic [31:0] force_pc = '0;
  // reference stream model
  logic [31:0] exp_pc = BOOT;
  int          delivered = 0;
  bit          exp_invalid = 0;
  bit          prev_req_hold = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] gnt_log[$];
  logic [31:0] pc_log[$];
  bit req_hist[$], rv_hist[$], val_hist[$], gnt_hist[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check and drive at negedge, advance the responder at posedge
  task automatic step();
    logic [31:0] g_addr;
    @(negedge clk);
    if (exp_invalid) begin
      check("valid_after_redirect", 64'(instr_valid_o), 64'd0);
      exp_invalid = 0;
    end
    if (prev_req_hold) begin
      check("req_held", 64'(instr_req_o), 64'd1);
      check("addr_held", 64'(instr_addr_o), 64'(prev_addr));
    end
    if (instr_req_o) begin
      check("one_outstanding", 64'(pend), 64'd0);
      check("addr_aligned", 64'(instr_addr_o[1:0]), 64'd0);
    end
    instr_gnt_i    = instr_req_o && ($urandom_range(99) < gnt_pct);
    instr_rvalid_i = force_rv || (pend && pend_dly == 0);
    instr_rdata_i  = force_rv ? 32'hDEAD_BEEF : (instr_rvalid_i ? mem_word(pend_addr) : $urandom);
    instr_ready_i  = ($urandom_range(99) < rdy_pct);
    redirect_i     = force_redir || (redir_pct > 0 && $urandom_range(99) < redir_pct);
    redirect_pc_i  = force_redir ? force_pc : $urandom;
    req_hist.push_back(instr_req_o);
    rv_hist.push_back(instr_rvalid_i);
    val_hist.push_back(instr_valid_o);
    gnt_hist.push_back(instr_gnt_i);
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      check("deliver_pc", 64'(instr_pc_o), 64'(exp_pc));
      check("deliver_data", 64'(instr_rdata_o), 64'(mem_word(exp_pc)));
      pc_log.push_back(instr_pc_o);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (redirect_i) begin
      exp_pc = redirect_pc_i & ~32'h3;
      exp_invalid = 1;
    end
    if (instr_gnt_i) gnt_log.push_back(instr_addr_o);
    g_addr = instr_addr_o;
    prev_req_hold = instr_req_o && !instr_gnt_i;
    prev_addr = instr_addr_o;
    @(posedge clk);
    if (instr_rvalid_i && !force_rv) pend = 0;
    else if (pend) pend_dly--;
    if (instr_gnt_i) begin
      pend = 1;
      pend_addr = g_addr;
      pend_dly = $urandom_range(dly_max);
    end
    force_redir = 0;
    force_rv = 0;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); pc_log.delete();
    req_hist.delete(); rv_hist.delete(); val_hist.delete(); gnt_hist.delete();
  endtask

  // Reset held for n cycles, then released just after a clock edge
  task automatic do_reset(input int n);
    #1 rst = 1;
    pend = 0; exp_pc = BOOT; exp_invalid = 0; prev_req_hold = 0;
    for (int i = 0; i < n; i++) step();
    #1 rst = 0;
  endtask

  task automatic run_until_delivered(input int n);
    int target;
    target = delivered + n;
    for (int i = 0; i < 300 && delivered < target; i++) step();
    check("progress", 64'(delivered >= target), 64'd1);
  endtask

  // Advance until a request is outstanding whose response is not due next cycle
  task automatic reach_wait();
    for (int i = 0; i < 100 && !(pend && pend_dly > 0); i++) step();
    check("reach_wait", 64'(pend && pend_dly > 0), 64'd1);
  endtask

  initial begin
    int r0, g0, g1, rvn;
    rst = 1; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0;
    redirect_i = 0; redirect_pc_i = '0; instr_ready_i = 0;

    // reset values
    for (int i = 0; i < 3; i++) step();
    #1;
    check("rst_req", 64'(instr_req_o), 64'd0);
    check("rst_addr", 64'(instr_addr_o), 64'(BOOT));
    check("rst_valid", 64'(instr_valid_o), 64'd0);
    check("rst_rdata", 64'(instr_rdata_o), 64'd0);
    check("rst_pc", 64'(instr_pc_o), 64'd0);

    // streaming: gnt with req, rvalid one cycle later, ready high
    clear_logs();
    rst = 0;
    gnt_pct = 100; rdy_pct = 100; dly_max = 0;
    run_until_delivered(3);
    check("first_req_lo", 64'(req_hist[0]), 64'd0);
    check("first_req_hi", 64'(req_hist[1]), 64'd1);
    check("gnt0", 64'(gnt_log[0]), 64'(BOOT));
    check("gnt1", 64'(gnt_log[1]), 64'(BOOT + 32'd4));
    check("gnt2", 64'(gnt_log[2]), 64'(BOOT + 32'd8));
    check("pc2", 64'(pc_log[2]), 64'(BOOT + 32'd8));
    r0 = -1; g0 = -1; g1 = -1;
    foreach (rv_hist[i]) if (rv_hist[i] && r0 < 0) r0 = i;
    foreach (gnt_hist[i]) if (gnt_hist[i]) begin
      if (g0 < 0) g0 = i; else if (g1 < 0) g1 = i;
    end
    check("lat_before", 64'(val_hist[r0]), 64'd0);
    check("lat_after", 64'(val_hist[r0+1]), 64'd1);
    check("throughput", 64'(g1 - g0), 64'd2);

    // backpressure: ready low for 10 cycles from reset
    do_reset(2);
    clear_logs();
    rdy_pct = 0;
    for (int i = 0; i < 10; i++) step();
    rvn = 0;
    foreach (rv_hist[i]) rvn += int'(rv_hist[i]);
    check("buffered_cnt", 64'(rvn), 64'd2);
    check("bp_req_low", 64'(req_hist[9] | req_hist[8] | req_hist[7]), 64'd0);
    #1;
    check("bp_valid", 64'(instr_valid_o), 64'd1);
    check("bp_head_pc", 64'(instr_pc_o), 64'(BOOT));
    check("bp_head_data", 64'(instr_rdata_o), 64'(mem_word(BOOT)));
    rdy_pct = 100;
    run_until_delivered(3);

    // redirect while a response is pending
    dly_max = 3;
    reach_wait();
    clear_logs();
    force_redir = 1; force_pc = 32'h0000_1002;
    step();
    for (int i = 0; i < 50 && gnt_log.size() == 0; i++) step();
    check("redir_req_addr", 64'(gnt_log.size() > 0 ? gnt_log[0] : 32'hX), 64'h1000);
    run_until_delivered(2);
    check("redir_first_pc", 64'(pc_log[0]), 64'h1000);

    // redirect + stray rvalid with FIFO full and ready high
    dly_max = 0; rdy_pct = 0;
    for (int i = 0; i < 10; i++) step();
    #1 check("full_before", 64'(instr_req_o), 64'd0);
    rdy_pct = 100; force_redir = 1; force_pc = 32'h0000_2000; force_rv = 1;
    step();
    #1 check("flush_empty", 64'(instr_valid_o), 64'd0);
    run_until_delivered(2);

    // redirect to top of address space wraps
    dly_max = 2;
    reach_wait();
    clear_logs();
    force_redir = 1; force_pc = 32'hFFFF_FFFC;
    step();
    for (int i = 0; i < 60 && gnt_log.size() < 2; i++) step();
    check("wrap_gnt0", 64'(gnt_log.size() > 0 ? gnt_log[0] : 32'hX), 64'hFFFF_FFFC);
    check("wrap_gnt1", 64'(gnt_log.size() > 1 ? gnt_log[1] : 32'hX), 64'h0);
    run_until_delivered(2);

    // reset during WAIT, then a late response after release
    dly_max = 3;
    reach_wait();
    do_reset(2);
    clear_logs();
    force_rv = 1;
    step();
    #1 check("late_rv_dropped", 64'(instr_valid_o), 64'd0);
    dly_max = 0;
    run_until_delivered(2);
    check("restart_addr", 64'(gnt_log[0]), 64'(BOOT));
    check("restart_pc", 64'(pc_log[0]), 64'(BOOT));

    // randomized traffic with occasional redirects
    gnt_pct = 60; rdy_pct = 70; dly_max = 3; redir_pct = 3;
    rvn = delivered;
    for (int i = 0; i < 3000; i++) step();
    check("rand_progress", 64'(delivered - rvn > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
